alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 Parameter SLT_SIGNED, default 0: 0 = unsigned SLT compare, 1 = two's-complement compare.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 START  input  1  request; sampled only in IDLE.
REQ-006 OPRN  input  6  opcode: 0x20 add, 0x22 sub, 0x2c mul, 0x02 srl, 0x01 sll, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt, 0x1a div (see Configuration).
REQ-007 OP1, OP2  input  DATA_WIDTH  operands.
REQ-008 BUSY  output  1  high while an operation is in progress.
REQ-009 DONE  output  1  one-cycle pulse when OUT/HI/ZERO/ERR are updated.
REQ-010 OUT  output  DATA_WIDTH  result (low product half, quotient).
REQ-011 HI  output  DATA_WIDTH  upper product half / remainder; 0 for other ops.
REQ-012 ZERO  output  1  high when OUT is all zeros.
REQ-013 ERR  output  1  illegal opcode or divide-by-zero for the last completed operation.

Function
REQ-014 FSM states IDLE, ITER, FIN; IDLE->FIN on START with single-cycle op or illegal opcode; IDLE->ITER on START with mul/div; ITER->FIN after DATA_WIDTH iterations; FIN->IDLE unconditionally.
REQ-015 OPRN, OP1, OP2 shall be captured on the START edge in IDLE; later input changes shall not affect the operation in progress.
REQ-016 START while BUSY or in FIN shall be ignored, not queued.
REQ-017 BUSY shall be high in ITER and FIN; low in IDLE.
REQ-018 Single-cycle ops: DONE shall pulse in the cycle after the START edge (latency 1).
REQ-019 Mul: unsigned radix-2 shift-add, one partial product per cycle; DONE shall pulse DATA_WIDTH+1 cycles after the START edge; {HI,OUT} = full 2*DATA_WIDTH product.
REQ-020 Add/sub shall wrap modulo 2^DATA_WIDTH; no overflow flag.
REQ-021 Shifts shall use the full OP2 value; shift amount >= DATA_WIDTH shall yield 0.
REQ-022 SLT shall yield 1 or 0 in bit 0, upper bits zero, compare per SLT_SIGNED.
REQ-023 Illegal opcode: OUT=0, HI=0, ZERO=1, ERR=1, latency 1.
REQ-024 OUT, HI, ZERO, ERR shall update only in the DONE cycle and hold until the next DONE.
REQ-025 START asserted in the same cycle as DONE shall be ignored; the next accepted START is the first one sampled in IDLE.

Reset
REQ-026 RST low shall immediately force IDLE, BUSY=0, DONE=0, OUT=0, HI=0, ZERO=1, ERR=0, iteration counter=0.
REQ-027 RST asserted mid-ITER shall abort the operation with no DONE pulse; the first START after deassertion starts cleanly.

Configuration
REQ-028 Macro ALU_MC_DIV_EN defined: opcode 0x1a shall perform unsigned restoring division, DATA_WIDTH iterations, DONE at DATA_WIDTH+1 cycles, OUT=quotient, HI=remainder.
REQ-029 With ALU_MC_DIV_EN: OP2=0 shall yield OUT=all ones, HI=OP1, ERR=1, same latency as normal division.
REQ-030 Without ALU_MC_DIV_EN: opcode 0x1a shall be treated as illegal per REQ-023, and no divider logic shall be present.

Verification
REQ-031 Width 32, START with 0x20, OP1=3, OP2=4 -> DONE 1 cycle later, OUT=7, ZERO=0, ERR=0; 0x22, 20-15 -> OUT=5.
REQ-032 0x2c, OP1=0xFFFFFFFF, OP2=2 -> BUSY 33 cycles, DONE at cycle 33, OUT=0xFFFFFFFE, HI=1; re-START during BUSY ignored.
REQ-033 0x02 8>>2 -> 2; 0x01 4<<4 -> 64; 0x01 OP2=40 -> OUT=0, ZERO=1; 0x27 3 nor 6 -> 0xFFFFFFF8.
REQ-034 0x2a OP1=0xFFFFFFFF, OP2=1 -> OUT=0 with SLT_SIGNED=0, OUT=1 with SLT_SIGNED=1; opcode 0x3f -> ERR=1, ZERO=1.
REQ-035 Mul started, RST pulsed low at iteration 10 -> BUSY=0, OUT=0, no DONE; subsequent 0x20 5+6 -> OUT=11.
REQ-036 With ALU_MC_DIV_EN: 0x1a 100/7 -> OUT=14, HI=2 after 33 cycles; 100/0 -> OUT=0xFFFFFFFF, ERR=1; without macro 0x1a -> ERR=1 after 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arithmetic ops, a radix-2
// shift-add multiplier and an optional restoring divider.
// Defining the macro ALU_MC_DIV_EN adds unsigned division on opcode 0x1a;
// without it that opcode is reported as illegal and no divider is built.
module alu_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int SLT_SIGNED = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [5:0]            OPRN,
   input  logic [DATA_WIDTH-1:0] OP1,
   input  logic [DATA_WIDTH-1:0] OP2,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [DATA_WIDTH-1:0] OUT,
   output logic [DATA_WIDTH-1:0] HI,
   output logic                  ZERO,
   output logic                  ERR
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]         LAST_ITER = CW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] WIDTH_VAL = DATA_WIDTH'(DATA_WIDTH);

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_MUL = 6'h2c;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_SLL = 6'h01;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SLT = 6'h2a;
`ifdef ALU_MC_DIV_EN
   localparam logic [5:0] OP_DIV = 6'h1a;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] acc_hi;
   logic [DATA_WIDTH-1:0] acc_lo;
   logic [DATA_WIDTH-1:0] opb;
   logic [CW-1:0]         cnt;
`ifdef ALU_MC_DIV_EN
   logic                  is_div;
   logic [DATA_WIDTH:0]   div_shift;
   logic [DATA_WIDTH:0]   div_trial;
   logic                  div_ok;
`endif

   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_ill;
   logic                  start_multi;
   logic                  slt_bit;
   logic                  shift_big;
   logic [CW-1:0]         shamt;
   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH-1:0] step_hi;
   logic [DATA_WIDTH-1:0] step_lo;
   logic                  iter_err;

   // Shifts honour the whole OP2 value: anything at or beyond the width clears the result.
   assign shift_big = (OP2 >= WIDTH_VAL);
   assign shamt     = OP2[CW-1:0];
   assign slt_bit   = (SLT_SIGNED != 0) ? ($signed(OP1) < $signed(OP2)) : (OP1 < OP2);

   // Result of every single-cycle opcode, computed straight from the live inputs on the START edge.
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (OPRN)
         OP_ADD:  alu_res = OP1 + OP2;
         OP_SUB:  alu_res = OP1 - OP2;
         OP_SRL:  alu_res = shift_big ? '0 : (OP1 >> shamt);
         OP_SLL:  alu_res = shift_big ? '0 : (OP1 << shamt);
         OP_AND:  alu_res = OP1 & OP2;
         OP_OR:   alu_res = OP1 | OP2;
         OP_NOR:  alu_res = ~(OP1 | OP2);
         OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
         OP_MUL:  alu_res = '0;
`ifdef ALU_MC_DIV_EN
         OP_DIV:  alu_res = '0;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // Opcodes that take the iterative path instead of finishing on the START edge.
   always_comb begin
      start_multi = (OPRN == OP_MUL);
`ifdef ALU_MC_DIV_EN
      start_multi = start_multi | (OPRN == OP_DIV);
`endif
   end

   // One iteration of the shared datapath: {acc_hi, acc_lo} starts as {0, OP1} and
   // after DATA_WIDTH steps holds the product, or the remainder/quotient for division.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      step_hi  = mul_sum[DATA_WIDTH:1];
      step_lo  = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
      iter_err = 1'b0;
`ifdef ALU_MC_DIV_EN
      div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
      div_trial = div_shift - {1'b0, opb};
      div_ok    = ~div_trial[DATA_WIDTH];
      if (is_div) begin
         step_hi  = div_ok ? div_trial[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
         step_lo  = {acc_lo[DATA_WIDTH-2:0], div_ok};
         iter_err = (opb == '0);
      end
`endif
   end

   // Control FSM with registered outputs; results change only in the DONE cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         OUT    <= '0;
         HI     <= '0;
         ZERO   <= 1'b1;
         ERR    <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         opb    <= '0;
         cnt    <= '0;
`ifdef ALU_MC_DIV_EN
         is_div <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  BUSY <= 1'b1;
                  if (start_multi) begin
                     state  <= ITER;
                     acc_hi <= '0;
                     acc_lo <= OP1;
                     opb    <= OP2;
                     cnt    <= '0;
`ifdef ALU_MC_DIV_EN
                     is_div <= (OPRN == OP_DIV);
`endif
                  end else begin
                     state <= FIN;
                     DONE  <= 1'b1;
                     OUT   <= alu_res;
                     HI    <= '0;
                     ZERO  <= (alu_res == '0);
                     ERR   <= alu_ill;
                  end
               end
            end
            ITER: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= FIN;
                  DONE  <= 1'b1;
                  OUT   <= step_lo;
                  HI    <= step_hi;
                  ZERO  <= (step_lo == '0);
                  ERR   <= iter_err;
               end
            end
            FIN: begin
               state <= IDLE;
               BUSY  <= 1'b0;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc. A second instance with SLT_SIGNED=1
// shares the inputs so both compare flavours are checked on every operation.
// Define ALU_MC_DIV_EN for both RTL and bench to exercise the divider.
module tb_alu_mc;

   localparam int W = 32;

   typedef struct packed {
      logic [31:0] out;
      logic [31:0] out_s;
      logic [31:0] hi;
      logic        err;
      logic [31:0] done_cyc;
   } exp_t;

   logic          CLK   = 1'b0;
   logic          RST   = 1'b0;
   logic          START = 1'b0;
   logic [5:0]    OPRN  = '0;
   logic [W-1:0]  OP1   = '0;
   logic [W-1:0]  OP2   = '0;
   logic          BUSY, DONE, ZERO, ERR;
   logic [W-1:0]  OUT, HI;
   logic          busy_s, done_s, zero_s, err_s;
   logic [W-1:0]  out_s, hi_s;

   int            tests = 0;
   int            fails = 0;
   int            cyc   = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   logic [W-1:0]  last_out  = '0;
   logic [W-1:0]  last_hi   = '0;
   logic          last_zero = 1'b1;
   logic          last_err  = 1'b0;

   alu_mc #(.DATA_WIDTH(W), .SLT_SIGNED(0)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
      .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .HI(HI), .ZERO(ZERO), .ERR(ERR)
   );

   alu_mc #(.DATA_WIDTH(W), .SLT_SIGNED(1)) dut_s (
      .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
      .BUSY(busy_s), .DONE(done_s), .OUT(out_s), .HI(hi_s), .ZERO(zero_s), .ERR(err_s)
   );

   // Free-running clock.
   always #5 CLK = ~CLK;

   // Count rising edges so expected DONE times can be stated in cycles.
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model written from the opcode definitions with plain arithmetic.
   function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] out, output logic [31:0] outs,
                                 output logic [31:0] hi, output logic err, output int lat);
      logic [63:0] p;
      out = '0; hi = '0; err = 1'b0; lat = 1;
      case (op)
         6'h20: out = a + b;
         6'h22: out = a - b;
         6'h2c: begin
            p   = 64'(a) * 64'(b);
            out = p[31:0];
            hi  = p[63:32];
            lat = W + 1;
         end
         6'h02: out = (b >= 32'd32) ? '0 : (a >> b);
         6'h01: out = (b >= 32'd32) ? '0 : (a << b);
         6'h24: out = a & b;
         6'h25: out = a | b;
         6'h27: out = ~(a | b);
         6'h2a: out = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MC_DIV_EN
         6'h1a: begin
            lat = W + 1;
            if (b == 0) begin
               out = 32'hFFFF_FFFF;
               hi  = a;
               err = 1'b1;
            end else begin
               out = a / b;
               hi  = a % b;
            end
         end
`endif
         default: err = 1'b1;
      endcase
      outs = out;
      if (op == 6'h2a) outs = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
   endfunction

   // Monitor: pops the scoreboard on every DONE and otherwise checks results are held.
   always @(negedge CLK) begin
      if (!RST) begin
         last_out  = '0;
         last_hi   = '0;
         last_zero = 1'b1;
         last_err  = 1'b0;
      end else if (DONE) begin
         if (sb.size() == 0) begin
            check_output("unexpected_done", DONE, 0);
         end else begin
            mon_e = sb.pop_front();
            check_output("out",     OUT,    mon_e.out);
            check_output("hi",      HI,     mon_e.hi);
            check_output("zero",    ZERO,   mon_e.out == 0);
            check_output("err",     ERR,    mon_e.err);
            check_output("busy_at_done", BUSY, 1);
            check_output("latency", cyc,    mon_e.done_cyc);
            check_output("done_signed", done_s, 1);
            check_output("out_signed",  out_s,  mon_e.out_s);
         end
         last_out  = OUT;
         last_hi   = HI;
         last_zero = ZERO;
         last_err  = ERR;
      end else begin
         check_output("hold", {OUT, HI, ZERO, ERR}, {last_out, last_hi, last_zero, last_err});
      end
   end

   // Wait (bounded) until the DUT is idle and every expected result has been seen.
   task automatic wait_idle();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (!BUSY && sb.size() == 0) break;
      end
      if (n == 100) begin
         check_output("idle_timeout", {BUSY, 32'(sb.size())}, 0);
         sb.delete();
      end
   endtask

   // Issue one operation; hold keeps START high through the following cycle.
   task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit hold, input bit push);
      exp_t e;
      int   lat;
      wait_idle();
      OPRN  = op;
      OP1   = a;
      OP2   = b;
      START = 1'b1;
      model(op, a, b, e.out, e.out_s, e.hi, e.err, lat);
      e.done_cyc = 32'(cyc + lat);
      if (push) sb.push_back(e);
      @(negedge CLK);
      OP1 = $urandom;
      OP2 = $urandom;
      if (hold) @(negedge CLK);
      START = 1'b0;
      OPRN  = 6'($urandom);
      OP1   = $urandom;
      OP2   = $urandom;
   endtask

   logic [5:0] ops [12] = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h01, 6'h24,
                            6'h25, 6'h27, 6'h2a, 6'h1a, 6'h3f, 6'h00};

   initial begin
      logic [5:0]  op;
      logic [31:0] a, b;
      repeat (2) @(negedge CLK);
      #1;
      check_output("rst_busy", BUSY, 0);
      check_output("rst_done", DONE, 0);
      check_output("rst_out",  OUT,  0);
      check_output("rst_hi",   HI,   0);
      check_output("rst_zero", ZERO, 1);
      check_output("rst_err",  ERR,  0);
      @(negedge CLK);
      RST = 1'b1;

      apply_stimulus(6'h20, 3, 4, 0, 1);
      apply_stimulus(6'h22, 20, 15, 1, 1);
      apply_stimulus(6'h2c, 32'hFFFF_FFFF, 2, 0, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         START = 1'b1;
         OPRN  = 6'h20;
         @(negedge CLK);
         START = 1'b0;
      end
      apply_stimulus(6'h02, 8, 2, 0, 1);
      apply_stimulus(6'h01, 4, 4, 0, 1);
      apply_stimulus(6'h01, 4, 40, 0, 1);
      apply_stimulus(6'h27, 3, 6, 0, 1);
      apply_stimulus(6'h2a, 32'hFFFF_FFFF, 1, 0, 1);
      apply_stimulus(6'h2a, 1, 32'hFFFF_FFFF, 0, 1);
      apply_stimulus(6'h3f, 9, 9, 1, 1);
      apply_stimulus(6'h1a, 100, 7, 0, 1);
      apply_stimulus(6'h1a, 100, 0, 0, 1);
      apply_stimulus(6'h20, 1, 2, 0, 1);

      // Abort a multiply around iteration 10; it must never report.
      apply_stimulus(6'h2c, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
      repeat (9) @(negedge CLK);
      RST = 1'b0;
      #1;
      check_output("abort_busy", BUSY, 0);
      check_output("abort_done", DONE, 0);
      check_output("abort_out",  OUT,  0);
      check_output("abort_zero", ZERO, 1);
      @(negedge CLK);
      RST = 1'b1;
      repeat (40) @(negedge CLK);
      apply_stimulus(6'h20, 5, 6, 0, 1);

      for (int i = 0; i < 60; i++) begin
         op = ops[$urandom_range(0, 11)];
         if (op == 6'h00) op = 6'($urandom);
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
         if ($urandom_range(0, 7) == 0) b = '0;
         apply_stimulus(op, a, b, 1'($urandom_range(0, 1)), 1);
      end

      wait_idle();
      check_output("sb_drain", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
